mantis1134_encoder: RTL and testbench

//  Reverse of the BITS-to-one-hot decoder: takes an IN_BITS-wide bit vector and

---
 rtl/mantis1134_pkg.sv | 16 +
 rtl/mantis1134_encoder_lsb.sv | 25 ++
 rtl/mantis1134_encoder.sv | 98 +++++++++
 tb/tb_mantis1134_encoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mantis1134_pkg.sv
// Shared types and helpers for the mantis1134 set-bit index encoder.
package mantis1134_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_BITS = 3;

    // Rebuilds a one-hot word from an index; sized for BITS up to 5.
    function automatic logic [31:0] idx_to_onehot(input logic [4:0] idx);
        return 32'(1) << idx;
    endfunction

endpackage

// File: rtl/mantis1134_encoder_lsb.sv
// Combinational lowest-set-bit finder: index, any-set and at-most-one-set flags.
module lsb_priority_encoder
    import mantis1134_pkg::*;
#(
    parameter  int unsigned BITS    = DEFAULT_BITS,
    localparam int unsigned IN_BITS = 1 << BITS
) (
    input  logic [IN_BITS-1:0] vec,
    output logic [BITS-1:0]    idx,
    output logic               any,
    output logic               single
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = int'(IN_BITS) - 1; i >= 0; i--) begin
            if (vec[i]) idx = BITS'(i);
        end
    end

    assign any    = |vec;
    assign single = ((vec & (vec - IN_BITS'(1))) == '0);

endmodule

// File: rtl/mantis1134_encoder.sv
// Streams the binary index of every set bit of a vector, lowest first, over valid/ready.
module mantis1134_encoder
    import mantis1134_pkg::*;
#(
    parameter  int unsigned BITS    = DEFAULT_BITS,
    localparam int unsigned IN_BITS = 1 << BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_BITS-1:0] A,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITS-1:0]    Y,
    output logic               out_last,
    output logic               out_zero
);

    if (BITS < 1) begin : g_bits_check
        $error("mantis1134_encoder: BITS must be >= 1");
    end

    state_t             r_state, w_state_nxt;
    logic [IN_BITS-1:0] r_pend, w_pend_nxt;
    logic               r_zflag, w_zflag_nxt;
    logic               r_valid, r_last, r_zero;
    logic [BITS-1:0]    r_y;
    logic [BITS-1:0]    w_idx;
    logic               w_any, w_single, w_beat;

    // Outputs are precomputed from the next pending vector so they leave the flops directly.
    lsb_priority_encoder #(.BITS(BITS)) u_enc (
        .vec    (w_pend_nxt),
        .idx    (w_idx),
        .any    (w_any),
        .single (w_single)
    );

    assign w_beat   = r_valid & out_ready;
    assign in_ready = !reset && ((r_state == IDLE) || (w_beat && r_last));

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_zflag_nxt = r_zflag;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_pend_nxt  = A;
                    w_zflag_nxt = (A == '0);
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_beat) begin
                    w_pend_nxt = r_pend & (r_pend - IN_BITS'(1));
                    if (r_last) begin
                        // Last beat taken: a waiting vector reloads with no bubble.
                        if (in_valid) begin
                            w_pend_nxt  = A;
                            w_zflag_nxt = (A == '0);
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_zflag <= 1'b0;
            r_valid <= 1'b0;
            r_y     <= '0;
            r_last  <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_zflag <= w_zflag_nxt;
            r_valid <= (w_state_nxt == EMIT);
            r_y     <= ((w_state_nxt == EMIT) && w_any) ? w_idx : '0;
            r_last  <= (w_state_nxt == EMIT) && w_single;
            r_zero  <= (w_state_nxt == EMIT) && w_zflag_nxt;
        end
    end

    assign out_valid = r_valid;
    assign Y         = r_y;
    assign out_last  = r_last;
    assign out_zero  = r_zero;

endmodule

// File: tb/tb_mantis1134_encoder.sv
// Directed and reference-model checks of mantis1134_encoder for BITS = 1, 3 and 5.
module tb_mantis1134_encoder;
    import mantis1134_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic        iv   [3];
    logic        ordy [3];
    wire         ir   [3];
    wire         ov   [3];
    wire         ol   [3];
    wire         oz   [3];
    logic [1:0]  a1;
    logic [7:0]  a3;
    logic [31:0] a5;
    wire  [0:0]  y1;
    wire  [2:0]  y3;
    wire  [4:0]  y5;

    int n_cmp = 0;
    int n_err = 0;

    mantis1134_encoder #(.BITS(1)) u_b1 (
        .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .A(a1),
        .out_valid(ov[0]), .out_ready(ordy[0]), .Y(y1), .out_last(ol[0]), .out_zero(oz[0]));
    mantis1134_encoder #(.BITS(3)) u_b3 (
        .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .A(a3),
        .out_valid(ov[1]), .out_ready(ordy[1]), .Y(y3), .out_last(ol[1]), .out_zero(oz[1]));
    mantis1134_encoder #(.BITS(5)) u_b5 (
        .clk(clk), .reset(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]), .A(a5),
        .out_valid(ov[2]), .out_ready(ordy[2]), .Y(y5), .out_last(ol[2]), .out_zero(oz[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_y(input int k);
        case (k)
            0:       return 32'(y1);
            1:       return 32'(y3);
            default: return 32'(y5);
        endcase
    endfunction

    task automatic set_a(input int k, input logic [31:0] v);
        case (k)
            0:       a1 = v[1:0];
            1:       a3 = v[7:0];
            default: a5 = v;
        endcase
    endtask

    // Feeds one vector and checks every beat against an independent lowest-bit model.
    task automatic run_vec(input int k, input logic [31:0] v);
        logic [31:0] rem;
        logic [31:0] acc;
        int          exp_idx;
        bit          fin;
        rem = v;
        acc = '0;
        fin = 1'b0;
        @(negedge clk);
        set_a(k, v);
        iv[k]   = 1'b1;
        ordy[k] = 1'b1;
        #1 check("rv_in_ready", 32'(ir[k]), 1);
        @(negedge clk);
        iv[k] = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            #1;
            check("rv_valid", 32'(ov[k]), 1);
            exp_idx = 0;
            for (int b = 31; b >= 0; b--) if (rem[b]) exp_idx = b;
            check("rv_y", get_y(k), 32'(exp_idx));
            check("rv_last", 32'(ol[k]), 32'((rem & (rem - 1)) == 0));
            check("rv_zero", 32'(oz[k]), 32'(v == 0));
            if (!oz[k]) acc = acc | idx_to_onehot(5'(get_y(k)));
            if (ol[k]) fin = 1'b1;
            rem = rem & (rem - 1);
            @(negedge clk);
        end
        if (!fin) check("rv_timeout", 0, 1);
        check("rv_or_of_beats", acc, v);
        #1 check("rv_idle_after", 32'(ov[k]), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        bit done;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b0;
        end
        a1 = '0; a3 = '0; a5 = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(ir[1]), 0);
        check("rst_valid", 32'(ov[1]), 0);
        check("rst_y", 32'(y3), 0);
        check("rst_last", 32'(ol[1]), 0);
        check("rst_zero", 32'(oz[1]), 0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        #1 check("post_rst_in_ready", 32'(ir[1]), 1);

        // 1: two set bits
        iv[1] = 1'b1; a3 = 8'b0001_0100; ordy[1] = 1'b1;
        @(negedge clk);
        iv[1] = 1'b0;
        #1;
        check("t1_valid0", 32'(ov[1]), 1);
        check("t1_y0", 32'(y3), 2);
        check("t1_last0", 32'(ol[1]), 0);
        check("t1_in_ready0", 32'(ir[1]), 0);
        @(negedge clk);
        #1;
        check("t1_y1", 32'(y3), 4);
        check("t1_last1", 32'(ol[1]), 1);
        check("t1_zero1", 32'(oz[1]), 0);
        @(negedge clk);
        #1;
        check("t1_idle", 32'(ov[1]), 0);
        check("t1_idle_y", 32'(y3), 0);

        // 2: zero vector
        iv[1] = 1'b1; a3 = 8'h00;
        @(negedge clk);
        iv[1] = 1'b0;
        #1;
        check("t2_valid", 32'(ov[1]), 1);
        check("t2_y", 32'(y3), 0);
        check("t2_zero", 32'(oz[1]), 1);
        check("t2_last", 32'(ol[1]), 1);
        @(negedge clk);
        #1;
        check("t2_idle", 32'(ov[1]), 0);
        check("t2_idle_zero", 32'(oz[1]), 0);

        // 3: all ones with out_ready toggling
        iv[1] = 1'b1; a3 = 8'hFF;
        @(negedge clk);
        iv[1] = 1'b0;
        beats = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            ordy[1] = (c % 2 == 0);
            #1;
            check("t3_valid", 32'(ov[1]), 1);
            check("t3_y", 32'(y3), 32'(beats));
            check("t3_last", 32'(ol[1]), 32'(beats == 7));
            if (ordy[1]) begin
                beats++;
                if (beats == 8) done = 1'b1;
            end
            @(negedge clk);
        end
        check("t3_beats", 32'(beats), 8);
        ordy[1] = 1'b1;
        #1 check("t3_idle", 32'(ov[1]), 0);

        // 4: back-to-back without a bubble
        iv[1] = 1'b1; a3 = 8'h80;
        @(negedge clk);
        a3 = 8'h01;
        #1;
        check("t4_y0", 32'(y3), 7);
        check("t4_last0", 32'(ol[1]), 1);
        check("t4_in_ready", 32'(ir[1]), 1);
        @(negedge clk);
        iv[1] = 1'b0;
        #1;
        check("t4_valid1", 32'(ov[1]), 1);
        check("t4_y1", 32'(y3), 0);
        check("t4_last1", 32'(ol[1]), 1);
        @(negedge clk);
        #1 check("t4_idle", 32'(ov[1]), 0);

        // 5: reset mid-vector drops remaining beats
        iv[1] = 1'b1; a3 = 8'hF0;
        @(negedge clk);
        iv[1] = 1'b0;
        #1 check("t5_y4", 32'(y3), 4);
        @(negedge clk);
        ordy[1] = 1'b0;
        rst[1]  = 1'b1;
        #1 check("t5_in_ready_rst", 32'(ir[1]), 0);
        @(negedge clk);
        #1 check("t5_valid_dropped", 32'(ov[1]), 0);
        rst[1]  = 1'b0;
        ordy[1] = 1'b1;
        #1 check("t5_in_ready_after", 32'(ir[1]), 1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 check("t5_no_beats", 32'(ov[1]), 0);
        end

        // 6: reference-model vectors for each width, plus all-ones edges
        run_vec(0, 32'h3);
        run_vec(0, 32'h2);
        run_vec(2, 32'hFFFF_FFFF);
        run_vec(2, 32'h8000_0001);
        for (int n = 0; n < 8; n++) run_vec(0, $urandom_range(0, 3));
        for (int n = 0; n < 12; n++) run_vec(1, $urandom_range(0, 255));
        for (int n = 0; n < 8; n++) run_vec(2, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
